mem_port_arbiter: RTL and testbench

Round-robin arbiter sharing one memory-side request port (w_req/w_ack, r_req/r_ack, addr, wdata, wstrb, rdata) between NUM_REQ AXI-lite slave front-ends. Sits between the slaves' memory-side interfaces and a single memory/register IP. Each grant stays locked to one requester until that requester drops its request, so every slave's level-held req/ack handshake passes through unmodified.

---
 rtl/axil_mem_pkg.sv | 20 ++
 rtl/mem_rr_pick.sv | 34 +++
 rtl/mem_port_arbiter.sv | 115 +++++++++++
 tb/tb_mem_port_arbiter.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/axil_mem_pkg.sv
// Shared definitions for the memory-port arbiter: one-hot FSM encodings
// and small index helpers used by the top and the round-robin picker.
package axil_mem_pkg;

    localparam logic [2:0] ARB_IDLE    = 3'b001;
    localparam logic [2:0] ARB_GRANT   = 3'b010;
    localparam logic [2:0] ARB_RELEASE = 3'b100;

    typedef enum logic [2:0] {
        ST_IDLE    = ARB_IDLE,
        ST_GRANT   = ARB_GRANT,
        ST_RELEASE = ARB_RELEASE
    } arb_state_e;

    // Width of a requester index; never narrower than one bit.
    function automatic int grant_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_rr_pick.sv
// Combinational round-robin picker: returns the first pending requester
// found searching upward from ptr, wrapping at NUM_REQ.
module mem_rr_pick
    import axil_mem_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int GW      = 1
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [GW-1:0]      ptr,
    output logic [GW-1:0]      winner,
    output logic               any_pending
);

    logic [GW:0] cand;

    // Walk the rotation from farthest to nearest so the nearest pending
    // candidate is the last (and therefore winning) assignment.
    always_comb begin
        winner      = ptr;
        cand        = '0;
        any_pending = |pending;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = {1'b0, ptr} + (GW + 1)'(k);
            if (cand >= (GW + 1)'(NUM_REQ)) begin
                cand = cand - (GW + 1)'(NUM_REQ);
            end
            if (pending[cand[GW-1:0]]) begin
                winner = cand[GW-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one level-handshake memory port between
// NUM_REQ requesters. A grant is held until its owner drops both requests,
// then one RELEASE cycle guarantees the memory sees req low between owners.
module mem_port_arbiter
    import axil_mem_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 64
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_REQ-1:0]            req_w_req,
    input  logic [NUM_REQ-1:0]            req_r_req,
    output logic [NUM_REQ-1:0]            req_w_ack,
    output logic [NUM_REQ-1:0]            req_r_ack,
    input  logic [NUM_REQ*ADDR_W-1:0]     req_addr,
    input  logic [NUM_REQ*DATA_W-1:0]     req_w_data,
    input  logic [NUM_REQ*DATA_W/8-1:0]   req_w_strb,
    output logic [DATA_W-1:0]             req_r_data,
    output logic                          mem_w_req,
    output logic                          mem_r_req,
    input  logic                          mem_w_ack,
    input  logic                          mem_r_ack,
    output logic [ADDR_W-1:0]             mem_addr,
    output logic [DATA_W-1:0]             mem_w_data,
    output logic [DATA_W/8-1:0]           mem_w_strb,
    input  logic [DATA_W-1:0]             mem_r_data,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy
);

    localparam int GW = grant_w(NUM_REQ);
    localparam int SW = DATA_W / 8;

    arb_state_e           state, state_nxt;
    logic [GW-1:0]        rr_ptr, ptr_nxt;
    logic [GW-1:0]        grant_nxt;
    logic [GW-1:0]        winner;
    logic                 any_pending;
    logic [NUM_REQ-1:0]   pending;
    logic                 in_grant;

    assign pending = req_w_req | req_r_req;

    mem_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .GW      (GW)
    ) u_pick (
        .pending     (pending),
        .ptr         (rr_ptr),
        .winner      (winner),
        .any_pending (any_pending)
    );

    // State, round-robin pointer and grant index registers.
    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state    <= ST_IDLE;
            rr_ptr   <= '0;
            grant_id <= '0;
        end else begin
            state    <= state_nxt;
            rr_ptr   <= ptr_nxt;
            grant_id <= grant_nxt;
        end
    end

    // Next-state: grant the picker's winner from IDLE, hold until the owner
    // goes quiet, then spend exactly one cycle in RELEASE.
    always_comb begin
        state_nxt = state;
        ptr_nxt   = rr_ptr;
        grant_nxt = grant_id;
        case (state)
            ST_IDLE: begin
                if (any_pending) begin
                    state_nxt = ST_GRANT;
                    grant_nxt = winner;
                    ptr_nxt   = (winner == GW'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                end
            end
            ST_GRANT: begin
                if (!req_w_req[grant_id] && !req_r_req[grant_id]) begin
                    state_nxt = ST_RELEASE;
                end
            end
            ST_RELEASE: state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // Downstream request and per-requester ack steering; only the owner
    // sees acks, and a simultaneous write takes precedence over a read.
    always_comb begin
        in_grant  = (state == ST_GRANT);
        mem_w_req = in_grant & req_w_req[grant_id];
        mem_r_req = in_grant & req_r_req[grant_id] & ~req_w_req[grant_id];
        req_w_ack = '0;
        req_r_ack = '0;
        if (in_grant) begin
            req_w_ack[grant_id] = mem_w_ack;
            req_r_ack[grant_id] = mem_r_ack & mem_r_req;
        end
    end

    // Payload muxes always follow grant_id; they are don't-care while the
    // downstream request is low.
    assign mem_addr   = req_addr  [grant_id*ADDR_W +: ADDR_W];
    assign mem_w_data = req_w_data[grant_id*DATA_W +: DATA_W];
    assign mem_w_strb = req_w_strb[grant_id*SW     +: SW];
    assign req_r_data = mem_r_data;
    assign busy       = in_grant;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic,
// every cycle compared against a behavioural model of the arbitration rules.
module tb_mem_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    logic            aclk;
    logic            rstn;
    logic [N-1:0]    wr, rd;
    logic [N-1:0]    req_w_ack, req_r_ack;
    logic [N*AW-1:0] addr_f;
    logic [N*DW-1:0] wdata_f;
    logic [N*SW-1:0] strb_f;
    logic [DW-1:0]   req_r_data;
    logic            mem_w_req, mem_r_req;
    logic            mwa, mra;
    logic [AW-1:0]   mem_addr;
    logic [DW-1:0]   mem_w_data;
    logic [SW-1:0]   mem_w_strb;
    logic [DW-1:0]   mrdata;
    logic [0:0]      grant_id;
    logic            busy;

    int nchk = 0;
    int errs = 0;

    // Reference model: phase 0 = free, 1 = owned, 2 = one-cycle gap.
    int m_phase = 0;
    int m_owner = 0;
    int m_next  = 0;
    bit mvalid  = 0;

    mem_port_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .aclk       (aclk),
        .aresetn    (rstn),
        .req_w_req  (wr),
        .req_r_req  (rd),
        .req_w_ack  (req_w_ack),
        .req_r_ack  (req_r_ack),
        .req_addr   (addr_f),
        .req_w_data (wdata_f),
        .req_w_strb (strb_f),
        .req_r_data (req_r_data),
        .mem_w_req  (mem_w_req),
        .mem_r_req  (mem_r_req),
        .mem_w_ack  (mwa),
        .mem_r_ack  (mra),
        .mem_addr   (mem_addr),
        .mem_w_data (mem_w_data),
        .mem_w_strb (mem_w_strb),
        .mem_r_data (mrdata),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nchk++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Expected outputs derived from the model's ownership and current inputs.
    task automatic check_outputs();
        logic [N-1:0] ewa, era;
        logic         eb, emw, emr;
        int           o;
        if (!mvalid) return;
        o   = m_owner;
        eb  = (m_phase == 1);
        emw = eb && wr[o];
        emr = eb && rd[o] && !wr[o];
        ewa = '0;
        era = '0;
        if (eb) begin
            ewa[o] = mwa;
            era[o] = mra && emr;
        end
        chk("busy",     64'(busy),       64'(eb));
        chk("grant_id", 64'(grant_id),   64'(o));
        chk("mem_w_req",64'(mem_w_req),  64'(emw));
        chk("mem_r_req",64'(mem_r_req),  64'(emr));
        chk("w_ack",    64'(req_w_ack),  64'(ewa));
        chk("r_ack",    64'(req_r_ack),  64'(era));
        chk("addr",     64'(mem_addr),   64'(addr_f[o*AW +: AW]));
        chk("wdata",    mem_w_data,      wdata_f[o*DW +: DW]);
        chk("strb",     64'(mem_w_strb), 64'(strb_f[o*SW +: SW]));
        chk("rdata",    req_r_data,      mrdata);
    endtask

    // Model step at the clock edge using the inputs the DUT just sampled.
    task automatic model_edge();
        if (!rstn) begin
            m_phase = 0;
            m_owner = 0;
            m_next  = 0;
            mvalid  = 1;
        end else if (mvalid) begin
            case (m_phase)
                0: begin
                    for (int k = 0; k < N; k++) begin
                        int c;
                        c = (m_next + k) % N;
                        if (wr[c] || rd[c]) begin
                            m_owner = c;
                            m_next  = (c + 1) % N;
                            m_phase = 1;
                            break;
                        end
                    end
                end
                1: if (!wr[m_owner] && !rd[m_owner]) m_phase = 2;
                default: m_phase = 0;
            endcase
        end
    endtask

    // One cycle: check settled outputs, take the edge, return at negedge.
    task automatic cyc();
        #1;
        check_outputs();
        @(posedge aclk);
        model_edge();
        @(negedge aclk);
    endtask

    task automatic quiet(input int n);
        wr = '0; rd = '0; mwa = 1'b0; mra = 1'b0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        cyc();
        rstn = 1'b1;
    endtask

    initial begin
        logic [N-1:0] seen;
        bit           prev_busy;
        int           ngr, low_cnt;

        rstn = 1'b0; wr = '0; rd = '0; mwa = 1'b0; mra = 1'b0;
        addr_f = '0; wdata_f = '0; strb_f = '0; mrdata = 64'hDEAD_BEEF_0000_0001;
        @(negedge aclk);

        // Reset with both requesters asserting writes.
        wr = 2'b11;
        cyc(); cyc();
        chk("rst_mem_w_req", 64'(mem_w_req), 64'(0));
        chk("rst_mem_r_req", 64'(mem_r_req), 64'(0));
        chk("rst_w_ack",     64'(req_w_ack), 64'(0));
        chk("rst_busy",      64'(busy),      64'(0));
        rstn = 1'b1;
        cyc();
        chk("rst_first_grant", 64'(grant_id), 64'(0));
        chk("rst_first_busy",  64'(busy),     64'(1));
        quiet(3);

        // Single write from requester 0, memory acks two cycles later.
        addr_f[0 +: AW]  = 32'h1000_0000;
        wdata_f[0 +: DW] = 64'h1122_3344_5566_7788;
        strb_f[0 +: SW]  = 8'hFF;
        wr = 2'b01;
        cyc();
        chk("sw_mem_w_req", 64'(mem_w_req),  64'(1));
        chk("sw_addr",      64'(mem_addr),   64'h1000_0000);
        chk("sw_wdata",     mem_w_data,      64'h1122_3344_5566_7788);
        chk("sw_strb",      64'(mem_w_strb), 64'hFF);
        cyc(); cyc();
        mwa = 1'b1;
        #1;
        chk("sw_w_ack", 64'(req_w_ack), 64'(2'b01));
        cyc();
        wr = 2'b00; mwa = 1'b0;
        cyc();
        chk("sw_release_busy", 64'(busy),      64'(0));
        chk("sw_release_req",  64'(mem_w_req), 64'(0));
        quiet(2);

        // Contention: both requesters read continuously.
        do_reset();
        rd = 2'b11; prev_busy = 1'b0; ngr = 0; low_cnt = 0;
        for (int c = 0; c < 200 && ngr < 8; c++) begin
            if (busy && !prev_busy) begin
                chk("rr_order", 64'(grant_id), 64'(ngr % 2));
                if (ngr > 0) chk("rr_gap", 64'(low_cnt), 64'(2));
                ngr++;
                low_cnt = 0;
            end
            if (!busy) low_cnt++;
            prev_busy = busy;
            seen = req_r_ack;
            rd = ~seen;
            #1 mra = mem_r_req;
            cyc();
        end
        chk("rr_grant_count", 64'(ngr), 64'(8));
        quiet(3);

        // Hold-off: requester 1 write waits behind a long requester 0 read.
        do_reset();
        addr_f[0 +: AW]  = 32'h1000_0000;
        addr_f[AW +: AW] = 32'h2000_0000;
        rd = 2'b01;
        cyc();
        wr = 2'b10; mra = 1'b1;
        for (int i = 0; i < 5; i++) begin
            cyc();
            chk("ho_no_ack1",  64'(req_w_ack[1]), 64'(0));
            chk("ho_no_wreq",  64'(mem_w_req),    64'(0));
            chk("ho_addr",     64'(mem_addr),     64'h1000_0000);
        end
        rd = 2'b00; mra = 1'b0;
        cyc();
        chk("ho_release", 64'(busy), 64'(0));
        cyc();
        cyc();
        chk("ho_grant1",  64'(grant_id),  64'(1));
        chk("ho_wreq1",   64'(mem_w_req), 64'(1));
        chk("ho_addr1",   64'(mem_addr),  64'h2000_0000);
        quiet(3);

        // Write and read together from one requester.
        do_reset();
        wr = 2'b01; rd = 2'b01;
        cyc();
        chk("both_wreq", 64'(mem_w_req), 64'(1));
        chk("both_rreq", 64'(mem_r_req), 64'(0));
        mra = 1'b1;
        #1;
        chk("both_r_ack", 64'(req_r_ack), 64'(0));

        // Reset mid-transaction while the write is being acked.
        mra = 1'b0; rd = 2'b00; mwa = 1'b1;
        #1;
        chk("mr_pre_ack", 64'(req_w_ack), 64'(2'b01));
        rstn = 1'b0; wr = 2'b11;
        cyc();
        chk("mr_wreq", 64'(mem_w_req), 64'(0));
        chk("mr_wack", 64'(req_w_ack), 64'(0));
        chk("mr_busy", 64'(busy),      64'(0));
        rstn = 1'b1; mwa = 1'b0;
        cyc();
        chk("mr_ptr_zero", 64'(grant_id), 64'(0));
        quiet(3);

        // Randomized traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            rstn = ($urandom_range(0, 149) != 0);
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) wr[i] = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0) rd[i] = 1'($urandom_range(0, 1));
                addr_f[i*AW +: AW]  = $urandom;
                wdata_f[i*DW +: DW] = {$urandom, $urandom};
                strb_f[i*SW +: SW]  = 8'($urandom);
            end
            mwa    = 1'($urandom_range(0, 1));
            mra    = 1'($urandom_range(0, 1));
            mrdata = {$urandom, $urandom};
            cyc();
        end

        $display("Result: errors=%0d of %0d checks", errs, nchk);
        $finish;
    end

endmodule
